// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared beat type and pointer sizing for the AXI-Stream FIFO
// The beat struct is sized for the widest supported tdata; users slice to DATA_WIDTH.
package axis_pkg;

   localparam int AXIS_MAX_DATA_W = 512;

   typedef struct packed {
      logic [AXIS_MAX_DATA_W-1:0]   data;
      logic [AXIS_MAX_DATA_W/8-1:0] keep;
      logic                         last;
   } axis_beat_t;

   // One extra MSB over the address so full and empty differ after wrap-around.
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// rtl/axis_fifo_mem.sv - register-array storage for the AXI-Stream FIFO
// Synchronous write, combinational read so the head entry falls through.
module axis_fifo_mem #(
   parameter int WIDTH = 73,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             wr_en_i,
   input  logic [AW-1:0]    wr_addr_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic [AW-1:0]    rd_addr_i,
   output logic [WIDTH-1:0] rd_data_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/axis_fifo.sv
// rtl/axis_fifo.sv - first-word-fall-through AXI-Stream FIFO with occupancy output
// Define AXIS_FIFO_PACKET_MODE_EN to hold beats until a whole packet is stored.
module axis_fifo
   import axis_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 16
) (
   input  logic                    aclk,
   input  logic                    areset,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic                    s_axis_tvalid,
   input  logic                    s_axis_tlast,
   output logic                    s_axis_tready,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic                    m_axis_tlast,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic [$clog2(DEPTH):0]  occupancy
);

   localparam int KW = DATA_WIDTH / 8;
   localparam int AW = $clog2(DEPTH);
   localparam int PW = ptr_width(DEPTH);
   localparam int WW = DATA_WIDTH + KW + 1;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic          ready_en_q;
   logic          full, empty, wr_en, rd_en;
   logic [WW-1:0] wr_word, rd_word;
   axis_beat_t    wr_beat, rd_beat;
   logic          unused_beat_bits;

   always_comb begin
      wr_beat                      = '0;
      wr_beat.data[DATA_WIDTH-1:0] = s_axis_tdata;
      wr_beat.keep[KW-1:0]         = s_axis_tkeep;
      wr_beat.last                 = s_axis_tlast;
   end

   always_comb begin
      rd_beat                      = '0;
      rd_beat.data[DATA_WIDTH-1:0] = rd_word[DATA_WIDTH-1:0];
      rd_beat.keep[KW-1:0]         = rd_word[DATA_WIDTH +: KW];
      rd_beat.last                 = rd_word[WW-1];
   end

   assign wr_word          = {wr_beat.last, wr_beat.keep[KW-1:0], wr_beat.data[DATA_WIDTH-1:0]};
   assign m_axis_tdata     = rd_beat.data[DATA_WIDTH-1:0];
   assign m_axis_tkeep     = rd_beat.keep[KW-1:0];
   assign m_axis_tlast     = rd_beat.last;
   assign unused_beat_bits = ^{wr_beat, rd_beat};

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign occupancy = wr_ptr_q - rd_ptr_q;

   // ready_en_q keeps tready low until the first edge after reset release.
   assign s_axis_tready = ready_en_q & ~full;
   assign wr_en         = s_axis_tvalid & s_axis_tready;
   assign rd_en         = m_axis_tvalid & m_axis_tready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         ready_en_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         ready_en_q <= 1'b1;
      end
   end

`ifdef AXIS_FIFO_PACKET_MODE_EN
   logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;
   logic          cut_q, cut_d;
   logic          wr_last, rd_last;

   assign wr_last = wr_en & s_axis_tlast;
   assign rd_last = rd_en & m_axis_tlast;

   // cut_q lets an oversize packet stream out once it has filled the FIFO, until its tlast leaves.
   always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      cut_d     = cut_q;
      if (wr_last && !rd_last) begin
         pkt_cnt_d = pkt_cnt_q + PW'(1);
      end else if (rd_last && !wr_last) begin
         pkt_cnt_d = pkt_cnt_q - PW'(1);
      end
      if (full && (pkt_cnt_q == '0)) cut_d = 1'b1;
      if (rd_last) cut_d = 1'b0;
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         pkt_cnt_q <= '0;
         cut_q     <= 1'b0;
      end else begin
         pkt_cnt_q <= pkt_cnt_d;
         cut_q     <= cut_d;
      end
   end

   assign m_axis_tvalid = ~empty & ((pkt_cnt_q != '0) | full | cut_q);
`else
   assign m_axis_tvalid = ~empty;
`endif

   axis_fifo_mem #(
      .WIDTH (WW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk_i     (aclk),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_ptr_q[AW-1:0]),
      .wr_data_i (wr_word),
      .rd_addr_i (rd_ptr_q[AW-1:0]),
      .rd_data_o (rd_word)
   );

endmodule

// File: tb/tb_axis_fifo.sv
// tb/tb_axis_fifo.sv - self-checking bench for axis_fifo against a queue model
// Packet-mode scenario runs when AXIS_FIFO_PACKET_MODE_EN is defined.
module tb_axis_fifo;

   localparam int DW    = 64;
   localparam int KW    = DW / 8;
   localparam int DEPTH = 16;

   logic          aclk = 1'b0;
   logic          areset;
   logic [DW-1:0] s_axis_tdata;
   logic [KW-1:0] s_axis_tkeep;
   logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;
   logic [DW-1:0] m_axis_tdata;
   logic [KW-1:0] m_axis_tkeep;
   logic          m_axis_tlast, m_axis_tvalid, m_axis_tready;
   logic [4:0]    occupancy;

   typedef struct {
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      logic          l;
   } beat_t;

   beat_t mq[$];
   bit    ready_en;
   int    n_tests = 0;
   int    n_fail  = 0;
`ifdef AXIS_FIFO_PACKET_MODE_EN
   bit    cut;
`endif

   always #5 aclk = ~aclk;

   axis_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .aclk          (aclk),
      .areset        (areset),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .occupancy     (occupancy)
   );

`ifdef AXIS_FIFO_PACKET_MODE_EN
   function automatic int n_lasts();
      int c = 0;
      foreach (mq[i]) if (mq[i].l) c++;
      return c;
   endfunction
`endif

   function automatic bit exp_ready();
      return ready_en && (mq.size() < DEPTH);
   endfunction

   function automatic bit exp_valid();
`ifdef AXIS_FIFO_PACKET_MODE_EN
      return (mq.size() > 0) && ((n_lasts() > 0) || (mq.size() == DEPTH) || cut);
`else
      return mq.size() > 0;
`endif
   endfunction

   // Advance one clock: model reacts to the handshakes it predicts, inputs stay as driven.
   task automatic cycle();
      bit    w, r;
      beat_t b;
      w   = s_axis_tvalid && exp_ready();
      r   = m_axis_tready && exp_valid();
      b.d = s_axis_tdata;
      b.k = s_axis_tkeep;
      b.l = s_axis_tlast;
      @(posedge aclk);
`ifdef AXIS_FIFO_PACKET_MODE_EN
      if (mq.size() == DEPTH && n_lasts() == 0) cut = 1'b1;
      if (r && mq[0].l) cut = 1'b0;
`endif
      if (r) void'(mq.pop_front());
      if (w) mq.push_back(b);
      ready_en = 1'b1;
      @(negedge aclk);
   endtask

   task automatic rand_beat(input bit last);
      s_axis_tdata = {$urandom, $urandom};
      s_axis_tkeep = KW'($urandom);
      s_axis_tlast = last;
   endtask

   task automatic reset_dut();
      areset = 1'b1;
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b0;
      @(negedge aclk);
      areset = 1'b0;
      mq.delete();
      ready_en = 1'b0;
`ifdef AXIS_FIFO_PACKET_MODE_EN
      cut = 1'b0;
`endif
      cycle();
   endtask

   task automatic test_reset();
      areset = 1'b1;
      s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
      m_axis_tready = 1'b0;
      repeat (2) @(negedge aclk);
      mq.delete();
      ready_en = 1'b0;
`ifdef AXIS_FIFO_PACKET_MODE_EN
      cut = 1'b0;
`endif
      n_tests++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready got %b exp 0", s_axis_tready); end
      n_tests++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got %b exp 0", m_axis_tvalid); end
      n_tests++; if (occupancy !== 5'd0) begin n_fail++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
      areset = 1'b0;
      cycle();
      n_tests++; if (s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL release_tready got %b exp 1", s_axis_tready); end
      n_tests++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL release_tvalid got %b exp 0", m_axis_tvalid); end
   endtask

   task automatic test_basic();
      reset_dut();
      m_axis_tready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         s_axis_tvalid = (i < 3);
         s_axis_tdata  = DW'(8'h11 * (i + 1));
         s_axis_tkeep  = '1;
         s_axis_tlast  = (i == 2);
         cycle();
         if (i == 0) begin
            n_tests++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 64'h11)
               begin n_fail++; $display("FAIL basic_first valid %b data %h exp 1 11", m_axis_tvalid, m_axis_tdata); end
         end
         n_tests++; if (m_axis_tvalid !== exp_valid()) begin n_fail++; $display("FAIL basic_valid got %b exp %b", m_axis_tvalid, exp_valid()); end
         n_tests++; if (occupancy !== 5'(mq.size())) begin n_fail++; $display("FAIL basic_occ got %0d exp %0d", occupancy, mq.size()); end
         if (exp_valid()) begin
            n_tests++;
            if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== {mq[0].d, mq[0].k, mq[0].l})
               begin n_fail++; $display("FAIL basic_data got %h exp %h", m_axis_tdata, mq[0].d); end
         end
      end
      n_tests++; if (occupancy !== 5'd0) begin n_fail++; $display("FAIL basic_drained got %0d exp 0", occupancy); end
   endtask

   task automatic test_full_wrap();
      bit acc;
      reset_dut();
      m_axis_tready = 1'b0;
      s_axis_tvalid = 1'b1;
      rand_beat(1'b1);
      for (int i = 0; i < 17; i++) begin
         acc = exp_ready();
         cycle();
         if (acc) rand_beat(1'b1);
         n_tests++; if (s_axis_tready !== exp_ready()) begin n_fail++; $display("FAIL fill_tready got %b exp %b", s_axis_tready, exp_ready()); end
      end
      n_tests++; if (occupancy !== 5'd16) begin n_fail++; $display("FAIL full_occ got %0d exp 16", occupancy); end
      n_tests++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL full_tready got %b exp 0", s_axis_tready); end
      n_tests++; if (m_axis_tdata !== mq[0].d) begin n_fail++; $display("FAIL full_head got %h exp %h", m_axis_tdata, mq[0].d); end
      m_axis_tready = 1'b1;
      cycle();
      m_axis_tready = 1'b0;
      n_tests++; if (occupancy !== 5'd15) begin n_fail++; $display("FAIL pulse_occ got %0d exp 15", occupancy); end
      n_tests++; if (s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL pulse_tready got %b exp 1", s_axis_tready); end
      m_axis_tready = 1'b1;
      for (int i = 0; i < 80; i++) begin
         s_axis_tvalid = (i < 60);
         acc = s_axis_tvalid && exp_ready();
         cycle();
         if (acc) rand_beat(1'b1);
         n_tests++; if (m_axis_tvalid !== exp_valid()) begin n_fail++; $display("FAIL wrap_valid got %b exp %b", m_axis_tvalid, exp_valid()); end
         n_tests++; if (occupancy !== 5'(mq.size())) begin n_fail++; $display("FAIL wrap_occ got %0d exp %0d", occupancy, mq.size()); end
         if (exp_valid()) begin
            n_tests++;
            if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== {mq[0].d, mq[0].k, mq[0].l})
               begin n_fail++; $display("FAIL wrap_data got %h exp %h", m_axis_tdata, mq[0].d); end
         end
      end
      n_tests++; if (occupancy !== 5'd0) begin n_fail++; $display("FAIL wrap_drained got %0d exp 0", occupancy); end
   endtask

   task automatic test_random_stall();
      int pos, len;
      bit acc;
      reset_dut();
      pos = 0;
      len = $urandom_range(1, 5);
      for (int i = 0; i < 300; i++) begin
         if (!s_axis_tvalid) begin
            s_axis_tvalid = (i < 260) && ($urandom_range(0, 9) < 7);
            s_axis_tdata  = {$urandom, $urandom};
            s_axis_tlast  = (pos == len - 1);
            s_axis_tkeep  = s_axis_tlast ? 8'h0F : 8'hFF;
         end
         m_axis_tready = (i >= 260) || $urandom_range(0, 1) == 1;
         if (m_axis_tready && exp_valid() && mq[0].l) begin
            n_tests++;
            if (m_axis_tkeep !== 8'h0F || m_axis_tlast !== 1'b1)
               begin n_fail++; $display("FAIL stall_lastkeep got %h/%b exp 0f/1", m_axis_tkeep, m_axis_tlast); end
         end
         acc = s_axis_tvalid && exp_ready();
         cycle();
         if (acc) begin
            if (s_axis_tlast) begin pos = 0; len = $urandom_range(1, 5); end
            else pos++;
            s_axis_tvalid = 1'b0;
         end
         n_tests++; if (m_axis_tvalid !== exp_valid()) begin n_fail++; $display("FAIL stall_valid got %b exp %b", m_axis_tvalid, exp_valid()); end
         n_tests++; if (s_axis_tready !== exp_ready()) begin n_fail++; $display("FAIL stall_tready got %b exp %b", s_axis_tready, exp_ready()); end
         n_tests++; if (occupancy !== 5'(mq.size())) begin n_fail++; $display("FAIL stall_occ got %0d exp %0d", occupancy, mq.size()); end
         if (exp_valid()) begin
            n_tests++;
            if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== {mq[0].d, mq[0].k, mq[0].l})
               begin n_fail++; $display("FAIL stall_data got %h exp %h", m_axis_tdata, mq[0].d); end
         end
      end
      s_axis_tvalid = 1'b0;
   endtask

`ifdef AXIS_FIFO_PACKET_MODE_EN
   task automatic test_packet();
      reset_dut();
      m_axis_tready = 1'b1;
      s_axis_tvalid = 1'b1;
      s_axis_tkeep  = '1;
      for (int i = 0; i < 4; i++) begin
         s_axis_tdata = DW'(i + 1);
         s_axis_tlast = (i == 3);
         cycle();
         n_tests++;
         if (m_axis_tvalid !== (i == 3)) begin n_fail++; $display("FAIL pkt_hold_valid beat %0d got %b exp %b", i, m_axis_tvalid, (i == 3)); end
      end
      n_tests++; if (m_axis_tdata !== 64'h1) begin n_fail++; $display("FAIL pkt_first got %h exp 1", m_axis_tdata); end
      s_axis_tvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         n_tests++; if (m_axis_tvalid !== exp_valid()) begin n_fail++; $display("FAIL pkt_drain_valid got %b exp %b", m_axis_tvalid, exp_valid()); end
         if (exp_valid()) begin
            n_tests++; if (m_axis_tdata !== mq[0].d) begin n_fail++; $display("FAIL pkt_drain_data got %h exp %h", m_axis_tdata, mq[0].d); end
         end
      end
      m_axis_tready = 1'b0;
      s_axis_tvalid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         rand_beat(1'b0);
         cycle();
         n_tests++;
         if (m_axis_tvalid !== (i == 15)) begin n_fail++; $display("FAIL pkt_oversize_valid beat %0d got %b exp %b", i, m_axis_tvalid, (i == 15)); end
      end
      s_axis_tvalid = 1'b0;
   endtask
`endif

   task automatic test_reset_mid();
      reset_dut();
      m_axis_tready = 1'b0;
      s_axis_tvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         rand_beat(i == 4);
         cycle();
      end
      s_axis_tvalid = 1'b0;
      n_tests++; if (occupancy !== 5'd5) begin n_fail++; $display("FAIL mid_stored got %0d exp 5", occupancy); end
      #2 areset = 1'b1;
      #1;
      mq.delete();
      ready_en = 1'b0;
`ifdef AXIS_FIFO_PACKET_MODE_EN
      cut = 1'b0;
`endif
      n_tests++; if (occupancy !== 5'd0) begin n_fail++; $display("FAIL mid_occ got %0d exp 0", occupancy); end
      n_tests++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL mid_tvalid got %b exp 0", m_axis_tvalid); end
      n_tests++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL mid_tready got %b exp 0", s_axis_tready); end
      @(negedge aclk);
      areset = 1'b0;
      cycle();
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 64'hAA;
      s_axis_tkeep  = '1;
      s_axis_tlast  = 1'b1;
      cycle();
      s_axis_tvalid = 1'b0;
      n_tests++; if (m_axis_tvalid !== 1'b1) begin n_fail++; $display("FAIL after_tvalid got %b exp 1", m_axis_tvalid); end
      n_tests++; if (m_axis_tdata !== 64'hAA) begin n_fail++; $display("FAIL after_data got %h exp aa", m_axis_tdata); end
      n_tests++; if (occupancy !== 5'd1) begin n_fail++; $display("FAIL after_occ got %0d exp 1", occupancy); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full_wrap();
      test_random_stall();
`ifdef AXIS_FIFO_PACKET_MODE_EN
      test_packet();
`endif
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/axis_fifo.md
AXIS_FIFO -- requirements
Module: axis_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning tdata width in bits (multiple of 8, at least 8).
REQ-002 SHALL have parameter DEPTH, default 16, meaning storage entries (power of two, at least 2).
REQ-003 SHALL have port aclk  input  1  meaning the single clock; all logic on rising edge.
REQ-004 SHALL have port areset  input  1  meaning reset, asynchronous and active-high.
REQ-005 SHALL have port s_axis_tdata  input  DATA_WIDTH  meaning write-side data.
REQ-006 SHALL have port s_axis_tkeep  input  DATA_WIDTH/8  meaning write-side byte enables.
REQ-007 SHALL have ports s_axis_tvalid, s_axis_tlast  input  1 each  meaning write valid and end of packet.
REQ-008 SHALL have port s_axis_tready  output  1  meaning FIFO can accept a beat.
REQ-009 SHALL have ports m_axis_tdata, m_axis_tkeep, m_axis_tlast  output  DATA_WIDTH, DATA_WIDTH/8, 1  meaning read-side beat.
REQ-010 SHALL have port m_axis_tvalid  output  1 and m_axis_tready  input  1  meaning read-side handshake.
REQ-011 SHALL have port occupancy  output  $clog2(DEPTH)+1  meaning stored beat count.

Function
REQ-012 SHALL transfer a beat on a side only when tvalid and tready are both high at a rising aclk edge.
REQ-013 SHALL store tdata, tkeep and tlast together per entry and present them unchanged in FIFO order.
REQ-014 SHALL use read/write pointers of $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty on wrap-around.
REQ-015 SHALL drive s_axis_tready = (occupancy != DEPTH), decoded from registered state only.
REQ-016 SHALL be first-word-fall-through: a beat written at edge N is visible on m_axis_* with m_axis_tvalid high after edge N (latency 1 cycle from empty).
REQ-017 SHALL hold m_axis_tdata/tkeep/tlast stable while m_axis_tvalid is high and m_axis_tready is low.
REQ-018 SHALL never drop m_axis_tvalid once asserted until the beat is accepted.
REQ-019 SHALL update occupancy +1 on write only, -1 on read only, unchanged on simultaneous write and read.
REQ-020 SHALL accept a simultaneous write and read when full, provided s_axis_tready is low (no write occurs), occupancy going DEPTH-1.
REQ-021 SHALL ignore s_axis_tvalid when s_axis_tready is low; no state changes.

Reset
REQ-022 SHALL, while areset is high, hold pointers at 0, occupancy 0, s_axis_tready 0, m_axis_tvalid 0, packet count 0.
REQ-023 SHALL drive s_axis_tready 1 in the first cycle after areset deasserts; storage contents need not be reset.
REQ-024 SHALL discard all stored beats, including partial packets, on reset asserted mid-transfer.

Configuration
REQ-025 SHALL implement store-and-forward packet mode only when macro AXIS_FIFO_PACKET_MODE_EN is defined.
REQ-026 SHALL, with the macro, keep a packet counter (+1 on tlast written, -1 on tlast read, unchanged on both) and assert m_axis_tvalid only when non-empty and counter > 0.
REQ-027 SHALL, with the macro, also assert m_axis_tvalid when full with counter 0 (oversize packet cut-through, no deadlock).
REQ-028 SHALL, without the macro, behave per REQ-016 with no packet counter logic.

Structure
REQ-029 SHALL place the axis beat struct typedef (data, keep, last) and a pointer-width function in shared package axis_pkg.
REQ-030 SHALL use one sub-module axis_fifo_mem (register-array storage, synchronous write, combinational read at read pointer).

Verification
REQ-031 Reset then write 0x11,0x22,0x33 (tlast on 0x33), m_axis_tready=1 -> same data out in order, 0x11 valid one cycle after its write, occupancy returns 0.
REQ-032 DEPTH=16, m_axis_tready=0, write 17 beats -> s_axis_tready low after 16th, occupancy 16, 17th beat held by source, no overwrite.
REQ-033 Full FIFO, pulse m_axis_tready one cycle -> one beat out, occupancy 15, s_axis_tready high next cycle; continuous streaming across pointer wrap shows no loss or duplicate.
REQ-034 Random m_axis_tready stalls with tkeep=0x0F on last beat -> m_axis outputs stable during stall, tkeep 0x0F delivered with tlast.
REQ-035 With AXIS_FIFO_PACKET_MODE_EN, write 3 beats without tlast -> m_axis_tvalid stays 0; write tlast beat -> tvalid 1 next cycle; 16 beats no tlast -> tvalid 1 at full.
REQ-036 Assert areset with 5 beats stored -> occupancy 0, m_axis_tvalid 0 immediately; after release, new beat 0xAA is first out.
